// File: rtl/alu_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_decoder
// Description : RV32IM decode-stage control generator. Decodes INSTRUCTION
//               combinationally and registers the ALU select code plus the
//               operand/writeback/memory controls into the ID/EX register.
//               Keeps a sticky illegal-instruction flag and a counter of
//               latched valid instructions.
// Ports       : clk_i, reset_i (async, active-high)
//               instruction_i, pc_i, in_valid_i   - IF/ID inputs
//               stall_i, flush_i, clear_illegal_i - pipeline control
//               alu_select_o, op1_sel_o, op2_sel_o, immediate_o,
//               rs1/rs2/rd_addr_o, reg_write_en_o, mem_read_o, mem_write_o,
//               branch_o, jump_o, funct3_o, muldiv_o, pc_o, out_valid_o,
//               illegal_o, illegal_sticky_o, decode_count_o
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_decoder #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        instruction_i,
  input  logic [31:0]        pc_i,
  input  logic               in_valid_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               clear_illegal_i,
  output logic [3:0]         alu_select_o,
  output logic               op1_sel_o,
  output logic [1:0]         op2_sel_o,
  output logic [31:0]        immediate_o,
  output logic [4:0]         rs1_addr_o,
  output logic [4:0]         rs2_addr_o,
  output logic [4:0]         rd_addr_o,
  output logic               reg_write_en_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               branch_o,
  output logic               jump_o,
  output logic [2:0]         funct3_o,
  output logic               muldiv_o,
  output logic [31:0]        pc_o,
  output logic               out_valid_o,
  output logic               illegal_o,
  output logic               illegal_sticky_o,
  output logic [COUNT_W-1:0] decode_count_o
);

  localparam logic [3:0] ALU_FWD = 4'b0000, ALU_ADD = 4'b0001, ALU_AND = 4'b0010,
                         ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLL = 4'b0101,
                         ALU_SRL = 4'b0110, ALU_SRA = 4'b0111, ALU_SUB = 4'b1000,
                         ALU_SLT = 4'b1001, ALU_SLTU = 4'b1010;

  localparam logic [1:0] OP2_RS2 = 2'b00, OP2_IMM = 2'b01, OP2_FOUR = 2'b10;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_JAL = 7'b1101111, OPC_JALR  = 7'b1100111,
                         OPC_BR  = 7'b1100011, OPC_LOAD  = 7'b0000011,
                         OPC_ST  = 7'b0100011, OPC_OPIMM = 7'b0010011,
                         OPC_OP  = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, F7_MULDIV = 7'b0000001;

  // Field extraction
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];
  assign imm_i  = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign imm_s  = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  assign imm_b  = {{19{instruction_i[31]}}, instruction_i[31], instruction_i[7],
                   instruction_i[30:25], instruction_i[11:8], 1'b0};
  assign imm_u  = {instruction_i[31:12], 12'b0};
  assign imm_j  = {{11{instruction_i[31]}}, instruction_i[31], instruction_i[19:12],
                   instruction_i[20], instruction_i[30:21], 1'b0};

  // Combinational decode results
  logic [3:0]  alu_d;
  logic        op1_d, rwe_d, mr_d, mw_d, br_d, jmp_d, md_d, legal_d;
  logic [1:0]  op2_d;
  logic [31:0] imm_d;
  logic [3:0]  alu_f3;

  // funct3 -> ALU code shared by OP and OP-IMM; shifts and SUB are resolved
  // separately because they also depend on funct7.
  always_comb begin
    alu_f3 = ALU_FWD;
    case (funct3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    alu_d   = ALU_FWD;
    op1_d   = 1'b0;
    op2_d   = OP2_RS2;
    imm_d   = 32'd0;
    rwe_d   = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    br_d    = 1'b0;
    jmp_d   = 1'b0;
    md_d    = 1'b0;
    legal_d = 1'b1;
    case (opcode)
      OPC_LUI: begin
        op2_d = OP2_IMM; imm_d = imm_u; rwe_d = 1'b1;
      end
      OPC_AUIPC: begin
        alu_d = ALU_ADD; op1_d = 1'b1; op2_d = OP2_IMM; imm_d = imm_u; rwe_d = 1'b1;
      end
      OPC_JAL: begin
        alu_d = ALU_ADD; op1_d = 1'b1; op2_d = OP2_FOUR; imm_d = imm_j;
        jmp_d = 1'b1; rwe_d = 1'b1;
      end
      OPC_JALR: begin
        alu_d = ALU_ADD; op1_d = 1'b1; op2_d = OP2_FOUR; imm_d = imm_i;
        jmp_d = 1'b1; rwe_d = 1'b1;
        legal_d = (funct3 == 3'b000);
      end
      OPC_BR: begin
        alu_d = ALU_SUB; imm_d = imm_b; br_d = 1'b1;
        legal_d = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        alu_d = ALU_ADD; op2_d = OP2_IMM; imm_d = imm_i; mr_d = 1'b1; rwe_d = 1'b1;
        legal_d = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
      end
      OPC_ST: begin
        alu_d = ALU_ADD; op2_d = OP2_IMM; imm_d = imm_s; mw_d = 1'b1;
        legal_d = (funct3[2] == 1'b0) && (funct3 != 3'b011);
      end
      OPC_OPIMM: begin
        op2_d = OP2_IMM; imm_d = imm_i; rwe_d = 1'b1; alu_d = alu_f3;
        if (funct3 == 3'b001) begin
          legal_d = (funct7 == F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) alu_d = ALU_SRA;
          else legal_d = (funct7 == F7_BASE);
        end
      end
      OPC_OP: begin
        rwe_d = 1'b1;
        if (funct7 == F7_BASE) begin
          alu_d = alu_f3;
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          alu_d = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          alu_d = ALU_SRA;
        end else if (funct7 == F7_MULDIV) begin
          md_d = 1'b1;  // result comes from the mul/div unit, ALU forwards
        end else begin
          legal_d = 1'b0;
        end
      end
      default: legal_d = 1'b0;
    endcase
    // An illegal instruction must never cause a side effect downstream.
    if (!legal_d) begin
      alu_d = ALU_FWD; op1_d = 1'b0; op2_d = OP2_RS2; imm_d = 32'd0;
      rwe_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; br_d = 1'b0; jmp_d = 1'b0; md_d = 1'b0;
    end
  end

  logic load_valid, bubble, sticky_d;
  assign load_valid = in_valid_i && !stall_i && !flush_i;
  assign bubble     = flush_i || (!stall_i && !in_valid_i);
  // Set beats clear when both occur on the same edge.
  assign sticky_d   = (illegal_sticky_o && !clear_illegal_i) || (load_valid && !legal_d);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      alu_select_o <= 4'd0;  op1_sel_o   <= 1'b0;  op2_sel_o   <= 2'd0;
      immediate_o  <= 32'd0; rs1_addr_o  <= 5'd0;  rs2_addr_o  <= 5'd0;
      rd_addr_o    <= 5'd0;  reg_write_en_o <= 1'b0; mem_read_o <= 1'b0;
      mem_write_o  <= 1'b0;  branch_o    <= 1'b0;  jump_o      <= 1'b0;
      funct3_o     <= 3'd0;  muldiv_o    <= 1'b0;  pc_o        <= 32'd0;
      out_valid_o  <= 1'b0;  illegal_o   <= 1'b0;
      illegal_sticky_o <= 1'b0;
      decode_count_o   <= '0;
    end else begin
      if (bubble) begin
        alu_select_o <= 4'd0;  op1_sel_o   <= 1'b0;  op2_sel_o   <= 2'd0;
        immediate_o  <= 32'd0; rs1_addr_o  <= 5'd0;  rs2_addr_o  <= 5'd0;
        rd_addr_o    <= 5'd0;  reg_write_en_o <= 1'b0; mem_read_o <= 1'b0;
        mem_write_o  <= 1'b0;  branch_o    <= 1'b0;  jump_o      <= 1'b0;
        funct3_o     <= 3'd0;  muldiv_o    <= 1'b0;  pc_o        <= 32'd0;
        out_valid_o  <= 1'b0;  illegal_o   <= 1'b0;
      end else if (!stall_i) begin
        alu_select_o   <= alu_d;
        op1_sel_o      <= op1_d;
        op2_sel_o      <= op2_d;
        immediate_o    <= imm_d;
        rs1_addr_o     <= instruction_i[19:15];
        rs2_addr_o     <= instruction_i[24:20];
        rd_addr_o      <= instruction_i[11:7];
        reg_write_en_o <= rwe_d;
        mem_read_o     <= mr_d;
        mem_write_o    <= mw_d;
        branch_o       <= br_d;
        jump_o         <= jmp_d;
        funct3_o       <= funct3;
        muldiv_o       <= md_d;
        pc_o           <= pc_i;
        out_valid_o    <= 1'b1;
        illegal_o      <= !legal_d;
      end
      illegal_sticky_o <= sticky_d;
      if (load_valid) decode_count_o <= decode_count_o + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_decoder
// Description : Self-checking bench for alu_control_decoder (COUNT_W=4).
//               Expected ID/EX contents are queued when an instruction is
//               driven and compared one edge later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_decoder;

  typedef struct packed {
    logic [3:0]  alu;
    logic        op1;
    logic [1:0]  op2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rwe;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic        md;
    logic [31:0] pc;
    logic        ov;
    logic        ill;
    logic        sticky;
    logic [3:0]  cnt;
  } out_t;

  typedef struct {
    out_t  val;
    out_t  mask;
    string name;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins, pc;
  logic        in_valid, stall, flush, clr;
  logic [3:0]  alu_o;
  logic        op1_o;
  logic [1:0]  op2_o;
  logic [31:0] imm_o, pc_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic        rwe_o, mr_o, mw_o, br_o, jmp_o, md_o, ov_o, ill_o, sticky_o;
  logic [2:0]  f3_o;
  logic [3:0]  cnt_o;

  out_t obs;
  sb_item_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [3:0] m_cnt = 4'd0;
  logic       m_sticky = 1'b0;
  out_t MASK_ALL, MASK_NOIMM, MASK_ILL, MASK_BUB;

  always #5 clk = ~clk;

  alu_control_decoder #(.COUNT_W(4)) dut (
    .clk_i(clk), .reset_i(rst), .instruction_i(ins), .pc_i(pc),
    .in_valid_i(in_valid), .stall_i(stall), .flush_i(flush),
    .clear_illegal_i(clr), .alu_select_o(alu_o), .op1_sel_o(op1_o),
    .op2_sel_o(op2_o), .immediate_o(imm_o), .rs1_addr_o(rs1_o),
    .rs2_addr_o(rs2_o), .rd_addr_o(rd_o), .reg_write_en_o(rwe_o),
    .mem_read_o(mr_o), .mem_write_o(mw_o), .branch_o(br_o), .jump_o(jmp_o),
    .funct3_o(f3_o), .muldiv_o(md_o), .pc_o(pc_o), .out_valid_o(ov_o),
    .illegal_o(ill_o), .illegal_sticky_o(sticky_o), .decode_count_o(cnt_o)
  );

  always_comb obs = {alu_o, op1_o, op2_o, imm_o, rs1_o, rs2_o, rd_o, rwe_o, mr_o,
                     mw_o, br_o, jmp_o, f3_o, md_o, pc_o, ov_o, ill_o, sticky_o, cnt_o};

  // Expected legal decode; register fields come straight from the encoding.
  function automatic out_t dec(input logic [31:0] i, input logic [31:0] p,
                               input logic [3:0] alu, input logic op1,
                               input logic [1:0] op2, input logic [31:0] imm,
                               input logic rwe, input logic mr, input logic mw,
                               input logic br, input logic jmp, input logic md);
    out_t e;
    e = '0;
    e.alu = alu; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
    e.rwe = rwe; e.mr = mr; e.mw = mw; e.br = br; e.jmp = jmp;
    e.f3 = i[14:12]; e.md = md; e.pc = p; e.ov = 1'b1;
    return e;
  endfunction

  function automatic out_t ill_exp(input logic [31:0] p);
    out_t e;
    e = '0;
    e.pc = p; e.ov = 1'b1; e.ill = 1'b1;
    return e;
  endfunction

  // Drives one edge, updates the sticky/count model and queues the expectation.
  task automatic drive(input logic [31:0] i, input logic [31:0] p, input logic v,
                       input logic st, input logic fl, input logic c,
                       input out_t e, input out_t m, input string nm);
    sb_item_t it;
    logic load;
    @(negedge clk);
    ins = i; pc = p; in_valid = v; stall = st; flush = fl; clr = c;
    load = v && !st && !fl;
    m_sticky = (m_sticky && !c) || (load && e.ill);
    if (load) m_cnt = m_cnt + 4'd1;
    e.sticky = m_sticky;
    e.cnt = m_cnt;
    it.val = e; it.mask = m; it.name = nm;
    sb.push_back(it);
    @(posedge clk);
    #1;
    ins = 32'd0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    sb_item_t it;
    out_t e;
    e = dec(32'h00500093, 32'h100, 4'b0001, 1'b0, 2'b01, 32'd5, 1, 0, 0, 0, 0, 0);
    drive(32'h00500093, 32'h100, 1, 0, 0, 0, e, MASK_ALL, "addi_before_reset");
    it = sb.pop_front();
    checks++;
    if ((obs & it.mask) !== (it.val & it.mask)) begin
      errors++;
      $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (obs !== out_t'(0)) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 4'd0; m_sticky = 1'b0;
    drive(32'h00500093, 32'h104, 1, 0, 0, 0, e, MASK_ALL, "addi_after_reset");
    it = sb.pop_front();
    it.val.pc = 32'h104;
    checks++;
    if ((obs & it.mask) !== (it.val & it.mask)) begin
      errors++;
      $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
    end
  endtask

  task automatic test_decode();
    logic [31:0] iv[12];
    out_t ev[12];
    out_t mv[12];
    sb_item_t it;
    logic [31:0] p;
    iv = '{32'hFFF00093, 32'h402081B3, 32'h40335293, 32'h00812203, 32'h00412623,
           32'h023100B3, 32'h123452B7, 32'h00001517, 32'h008000EF, 32'h00208463,
           32'h0020E1B3, 32'h000080E7};
    for (int k = 0; k < 12; k++) begin
      p = 32'h200 + 32'(k * 4);
      mv[k] = MASK_ALL;
      case (k)
        0:  ev[k] = dec(iv[k], p, 4'b0001, 0, 2'b01, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0);
        1:  begin ev[k] = dec(iv[k], p, 4'b1000, 0, 2'b00, 32'd0, 1, 0, 0, 0, 0, 0); mv[k] = MASK_NOIMM; end
        2:  ev[k] = dec(iv[k], p, 4'b0111, 0, 2'b01, 32'h403, 1, 0, 0, 0, 0, 0);
        3:  ev[k] = dec(iv[k], p, 4'b0001, 0, 2'b01, 32'd8, 1, 1, 0, 0, 0, 0);
        4:  ev[k] = dec(iv[k], p, 4'b0001, 0, 2'b01, 32'd12, 0, 0, 1, 0, 0, 0);
        5:  begin ev[k] = dec(iv[k], p, 4'b0000, 0, 2'b00, 32'd0, 1, 0, 0, 0, 0, 1); mv[k] = MASK_NOIMM; end
        6:  ev[k] = dec(iv[k], p, 4'b0000, 0, 2'b01, 32'h12345000, 1, 0, 0, 0, 0, 0);
        7:  ev[k] = dec(iv[k], p, 4'b0001, 1, 2'b01, 32'h1000, 1, 0, 0, 0, 0, 0);
        8:  ev[k] = dec(iv[k], p, 4'b0001, 1, 2'b10, 32'd8, 1, 0, 0, 0, 1, 0);
        9:  ev[k] = dec(iv[k], p, 4'b1000, 0, 2'b00, 32'd8, 0, 0, 0, 1, 0, 0);
        10: begin ev[k] = dec(iv[k], p, 4'b0011, 0, 2'b00, 32'd0, 1, 0, 0, 0, 0, 0); mv[k] = MASK_NOIMM; end
        default: ev[k] = dec(iv[k], p, 4'b0001, 1, 2'b10, 32'd0, 1, 0, 0, 0, 1, 0);
      endcase
      drive(iv[k], p, 1, 0, 0, 0, ev[k], mv[k], $sformatf("decode_%h", iv[k]));
      it = sb.pop_front();
      checks++;
      if ((obs & it.mask) !== (it.val & it.mask)) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
      end
    end
  endtask

  task automatic test_stall_flush();
    sb_item_t it;
    out_t held;
    held = dec(32'h00500093, 32'h300, 4'b0001, 0, 2'b01, 32'd5, 1, 0, 0, 0, 0, 0);
    drive(32'h00500093, 32'h300, 1, 0, 0, 0, held, MASK_ALL, "addi_before_stall");
    for (int k = 0; k < 4; k++) begin
      if (k > 0)
        drive(32'h402081B3 + 32'(k), 32'h400 + 32'(k), 1, 1, 0, 0, held, MASK_ALL,
              $sformatf("stall_hold_%0d", k));
      it = sb.pop_front();
      checks++;
      if ((obs & it.mask) !== (it.val & it.mask)) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
      end
    end
    drive(32'h00500093, 32'h500, 1, 1, 1, 0, out_t'(0), MASK_BUB, "stall_and_flush");
    it = sb.pop_front();
    checks++;
    if ((obs & it.mask) !== (it.val & it.mask)) begin
      errors++;
      $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] iv[6];
    logic        cv[6];
    sb_item_t it;
    out_t e, m;
    logic [31:0] p;
    iv = '{32'hFFFFFFFF, 32'h00500093, 32'h0020A463, 32'h40109093, 32'h00000000, 32'h00500093};
    cv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 6; k++) begin
      p = 32'h600 + 32'(k * 4);
      if (iv[k] == 32'h00500093) begin
        e = dec(iv[k], p, 4'b0001, 0, 2'b01, 32'd5, 1, 0, 0, 0, 0, 0);
        m = MASK_ALL;
      end else begin
        e = ill_exp(p);
        m = MASK_ILL;
      end
      drive(iv[k], p, 1, 0, 0, cv[k], e, m, $sformatf("illegal_seq_%0d", k));
      it = sb.pop_front();
      checks++;
      if ((obs & it.mask) !== (it.val & it.mask)) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
      end
    end
  endtask

  task automatic test_count_wrap();
    sb_item_t it;
    out_t e;
    for (int k = 0; k < 19; k++) begin
      if (k < 16) begin
        e = dec(32'h00500093, 32'h700 + 32'(k * 4), 4'b0001, 0, 2'b01, 32'd5, 1, 0, 0, 0, 0, 0);
        drive(32'h00500093, 32'h700 + 32'(k * 4), 1, 0, 0, 0, e, MASK_ALL,
              $sformatf("count_load_%0d", k));
      end else begin
        drive(32'h00500093, 32'h800, 0, 0, 0, 0, out_t'(0), MASK_BUB,
              $sformatf("count_bubble_%0d", k));
      end
      it = sb.pop_front();
      checks++;
      if ((obs & it.mask) !== (it.val & it.mask)) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.name, obs & it.mask, it.val & it.mask);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    MASK_ALL = '1;
    MASK_NOIMM = '1;
    MASK_NOIMM.imm = '0;
    MASK_BUB = '0;
    MASK_BUB.rwe = 1; MASK_BUB.mr = 1; MASK_BUB.mw = 1; MASK_BUB.br = 1;
    MASK_BUB.jmp = 1; MASK_BUB.md = 1; MASK_BUB.ov = 1; MASK_BUB.ill = 1;
    MASK_BUB.sticky = 1; MASK_BUB.cnt = '1;
    MASK_ILL = MASK_BUB;
    MASK_ILL.alu = '1; MASK_ILL.pc = '1;
    rst = 1'b1; ins = 32'd0; pc = 32'd0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
    #12;
    checks++;
    if (obs !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_decode();
    test_stall_flush();
    test_illegal();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
